// File: rtl/maxpool2d_stream_pkg.sv
// maxpool_pkg: shared constants, row-phase type and helpers for the 2x2 max-pool stream
package maxpool_pkg;
  localparam int R_DEF = 4;
  localparam int W_DEF = 8;
  typedef logic [W_DEF-1:0] pix_t;
  typedef enum logic {EVEN, ODD} row_t;
  function automatic int bpr(input int cols, input int r);
    return cols / r;
  endfunction
endpackage

// File: rtl/maxpool2d_stream_if.sv
// maxpool2d_stream_if: valid/ready pixel stream carrying N pixels per beat
interface maxpool2d_stream_if import maxpool_pkg::*; #(
  parameter int N = R_DEF,
  parameter int W = W_DEF
);
  logic               valid;
  logic               ready;
  logic               last;
  logic [N-1:0][W-1:0] data;
  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/maxpool2d_stream_cmp.sv
// maxpool_cmp: two-input max, two's-complement or unsigned compare by parameter
module maxpool_cmp import maxpool_pkg::*; #(
  parameter int W      = W_DEF,
  parameter bit SIGNED = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  logic ge;
  always_comb begin
    ge = SIGNED ? ($signed(a) >= $signed(b)) : (a >= b);
    y  = ge ? a : b;
  end
endmodule

// File: rtl/maxpool2d_stream.sv
// maxpool2d_stream: 2x2/stride-2 streaming max-pool; even rows fill a line buffer,
// odd rows pool against it and emit one R/2-pixel beat per accepted beat.
module maxpool2d_stream import maxpool_pkg::*; #(
  parameter int R      = R_DEF,
  parameter int W      = W_DEF,
  parameter int COLS   = 16,
  parameter bit SIGNED = 1'b0
) (
  input logic                clk,
  input logic                rstn,
  maxpool2d_stream_if.slave  s,
  maxpool2d_stream_if.master m,
  output logic               frame_err
);
  localparam int BPR = bpr(COLS, R);
  localparam int H   = R / 2;
  localparam int CW  = BPR > 1 ? $clog2(BPR) : 1;

  if (R < 2 || R % 2 != 0 || COLS % R != 0 || W < 1) begin : g_bad_params
    $error("maxpool2d_stream: illegal R/W/COLS combination");
  end

  row_t                 row, row_nx;
  logic [CW-1:0]        col, col_nx;
  logic                 acc, end_row;
  logic [H-1:0][W-1:0]  hmax, vmax;
  logic [H-1:0][W-1:0]  lbuf [BPR];

  for (genvar i = 0; i < H; i++) begin : g_cmp
    maxpool_cmp #(.W(W), .SIGNED(SIGNED)) u_h (.a(s.data[2*i]), .b(s.data[2*i+1]), .y(hmax[i]));
    maxpool_cmp #(.W(W), .SIGNED(SIGNED)) u_v (.a(lbuf[col][i]), .b(hmax[i]), .y(vmax[i]));
  end

  // s_last always restarts the next frame at an even row, column 0
  always_comb begin
    s.ready = row == EVEN || !m.valid || m.ready;
    acc     = s.valid && s.ready;
    end_row = col == CW'(BPR - 1);
    col_nx  = col;
    row_nx  = row;
    if (acc) begin
      col_nx = (end_row || s.last) ? '0 : col + CW'(1);
      row_nx = s.last ? EVEN : end_row ? (row == EVEN ? ODD : EVEN) : row;
    end
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      row <= EVEN;
      col <= '0;
    end else begin
      row <= row_nx;
      col <= col_nx;
    end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      m.valid   <= 1'b0;
      m.data    <= '0;
      m.last    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (acc && row == ODD) begin
        m.valid <= 1'b1;
        m.data  <= vmax;
        m.last  <= s.last;
      end else if (m.ready) begin
        m.valid <= 1'b0;
      end
      if (acc && s.last && !(end_row && row == ODD)) frame_err <= 1'b1;
    end

  // each entry is written on the even row before the odd row reads it, so no reset
  always_ff @(posedge clk)
    if (acc && row == EVEN) lbuf[col] <= hmax;
endmodule

// File: tb/tb_maxpool2d_stream.sv
// tb_maxpool2d_stream: unsigned and signed instances driven in lockstep and checked
// against a pixel-array 2x2 max model.
module tb_maxpool2d_stream;
  import maxpool_pkg::*;
  localparam int R = 4, W = 8, COLS = 8, BPR = bpr(COLS, R), H = R / 2;
  typedef logic [R-1:0][W-1:0] beat_t;
  typedef logic [H-1:0][W-1:0] obeat_t;
  typedef struct packed {obeat_t d; logic last;} exp_t;

  logic clk = 1'b0, rstn = 1'b0, mready = 1'b1;
  logic err0, err1;
  always #5 clk = ~clk;

  maxpool2d_stream_if #(.N(R), .W(W)) si0 (), si1 ();
  maxpool2d_stream_if #(.N(H), .W(W)) mo0 (), mo1 ();
  assign si1.valid = si0.valid;
  assign si1.data  = si0.data;
  assign si1.last  = si0.last;
  assign mo0.ready = mready;
  assign mo1.ready = mready;

  maxpool2d_stream #(.R(R), .W(W), .COLS(COLS), .SIGNED(1'b0)) u_uns (
    .clk(clk), .rstn(rstn), .s(si0), .m(mo0), .frame_err(err0));
  maxpool2d_stream #(.R(R), .W(W), .COLS(COLS), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rstn(rstn), .s(si1), .m(mo1), .frame_err(err1));

  int vec = 0, errs = 0, n_out = 0, n_last = 0;
  exp_t q0[$], q1[$];
  int mcol;
  bit modd, exp_err;
  pix_t evn[COLS];

  function automatic int val(input pix_t p, input bit sg);
    return sg ? int'($signed(p)) : int'(p);
  endfunction

  function automatic pix_t max4(input pix_t a, input pix_t b, input pix_t c, input pix_t d, input bit sg);
    pix_t x = a;
    if (val(b, sg) > val(x, sg)) x = b;
    if (val(c, sg) > val(x, sg)) x = c;
    if (val(d, sg) > val(x, sg)) x = d;
    return x;
  endfunction

  function automatic beat_t mk(input pix_t a, input pix_t b, input pix_t c, input pix_t d);
    beat_t x;
    x[0] = a; x[1] = b; x[2] = c; x[3] = d;
    return x;
  endfunction

  function automatic beat_t rb();
    beat_t x;
    for (int i = 0; i < R; i++) x[i] = pix_t'($urandom);
    return x;
  endfunction

  task automatic model_reset();
    mcol = 0; modd = 0; exp_err = 0;
    q0.delete(); q1.delete();
  endtask

  task automatic model_beat(input beat_t d, input logic last);
    if (!modd) begin
      for (int p = 0; p < R; p++) evn[mcol*R+p] = d[p];
    end else begin
      exp_t e0, e1;
      for (int j = 0; j < H; j++) begin
        int b;
        b = mcol * R + 2 * j;
        e0.d[j] = max4(evn[b], evn[b+1], d[2*j], d[2*j+1], 1'b0);
        e1.d[j] = max4(evn[b], evn[b+1], d[2*j], d[2*j+1], 1'b1);
      end
      e0.last = last; e1.last = last;
      q0.push_back(e0); q1.push_back(e1);
    end
    if (last && !(mcol == BPR - 1 && modd)) exp_err = 1;
    if (last) begin
      mcol = 0; modd = 0;
    end else if (mcol == BPR - 1) begin
      mcol = 0; modd = !modd;
    end else begin
      mcol++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mo0.valid && mo0.ready) begin
      vec++; n_out++;
      if (mo0.last) n_last++;
      if (q0.size() == 0) begin
        errs++; $display("FAIL out_uns unexpected beat got %h last %b", mo0.data, mo0.last);
      end else begin
        e = q0.pop_front();
        if ({mo0.data, mo0.last} !== e) begin
          errs++; $display("FAIL out_uns got %h/%b exp %h/%b", mo0.data, mo0.last, e.d, e.last);
        end
      end
    end
    if (mo1.valid && mo1.ready) begin
      vec++;
      if (q1.size() == 0) begin
        errs++; $display("FAIL out_sgn unexpected beat got %h last %b", mo1.data, mo1.last);
      end else begin
        e = q1.pop_front();
        if ({mo1.data, mo1.last} !== e) begin
          errs++; $display("FAIL out_sgn got %h/%b exp %h/%b", mo1.data, mo1.last, e.d, e.last);
        end
      end
    end
  end

  task automatic send(input beat_t d, input logic last, output int stalls);
    stalls = 0;
    si0.valid = 1'b1; si0.data = d; si0.last = last;
    @(negedge clk);
    while (!si0.ready && stalls < 64) begin
      stalls++;
      @(negedge clk);
    end
    vec++;
    if (!si0.ready) begin
      errs++; $display("FAIL send_timeout ready %b after %0d cycles, required 1", si0.ready, stalls);
    end else begin
      model_beat(d, last);
    end
    @(posedge clk); #1;
    si0.valid = 1'b0; si0.last = 1'b0;
  endtask

  task automatic send_frame(input int rows, output int stalls);
    int s;
    stalls = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < BPR; c++) begin
        send(rb(), r == rows - 1 && c == BPR - 1, s);
        stalls += s;
      end
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
    #1;
    vec++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errs++; $display("FAIL drain pending %0d/%0d beats, required 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    si0.valid = 1'b0; si0.last = 1'b0; si0.data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({mo0.valid, mo0.last, mo0.data, err0, mo1.valid, err1} !== '0) begin
      errs++; $display("FAIL reset_outputs got v%b l%b d%h e%b sv%b se%b, required zeros",
                       mo0.valid, mo0.last, mo0.data, err0, mo1.valid, err1);
    end
    vec++;
    if (si0.ready !== 1'b1) begin
      errs++; $display("FAIL reset_ready got %b required 1", si0.ready);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int s;
    send(mk(1, 2, 3, 4), 0, s);
    send(mk(5, 6, 7, 8), 0, s);
    vec++;
    if (mo0.valid !== 1'b0) begin
      errs++; $display("FAIL basic_row0_quiet m_valid %b required 0", mo0.valid);
    end
    send(mk(9, 0, 0, 10), 0, s);
    vec++;
    if (mo0.valid !== 1'b1 || mo0.data !== {8'd10, 8'd9} || mo0.last !== 1'b0) begin
      errs++; $display("FAIL basic_first got v%b %h l%b required 1 0a09 0", mo0.valid, mo0.data, mo0.last);
    end
    send(mk(0, 0, 0, 0), 1, s);
    vec++;
    if (mo0.valid !== 1'b1 || mo0.data !== {8'd8, 8'd6} || mo0.last !== 1'b1) begin
      errs++; $display("FAIL basic_second got v%b %h l%b required 1 0806 1", mo0.valid, mo0.data, mo0.last);
    end
    drain();
  endtask

  task automatic test_signed();
    int s;
    send(mk(8'hFF, 8'h01, 8'h80, 8'h7F), 0, s);
    send(rb(), 0, s);
    send(mk(8'hFE, 8'hFD, 8'h80, 8'h80), 0, s);
    vec++;
    if (mo0.data !== {8'h80, 8'hFF}) begin
      errs++; $display("FAIL signed_uns_mode got %h required 80ff", mo0.data);
    end
    vec++;
    if (mo1.data !== {8'h7F, 8'h01}) begin
      errs++; $display("FAIL signed_sgn_mode got %h required 7f01", mo1.data);
    end
    send(rb(), 1, s);
    drain();
  endtask

  task automatic test_backpressure();
    int s, o;
    fork
      begin
        int st;
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < BPR; c++) send(rb(), 0, st);
      end
      begin
        obeat_t hold;
        for (int k = 0; k < 40 && !mo0.valid; k++) begin
          @(posedge clk); #1;
        end
        vec++;
        if (!mo0.valid) begin
          errs++; $display("FAIL bp_first_output m_valid %b required 1", mo0.valid);
        end
        mready = 1'b0;
        hold = mo0.data;
        repeat (5) begin
          @(negedge clk);
          vec++;
          if (mo0.data !== hold || mo0.valid !== 1'b1 || si0.ready !== 1'b0) begin
            errs++; $display("FAIL bp_hold got %h v%b s_ready %b required %h v1 s_ready 0",
                             mo0.data, mo0.valid, si0.ready, hold);
          end
        end
        @(posedge clk); #1;
        mready = 1'b1;
      end
    join
    mready = 1'b0;
    o = n_out;
    for (int c = 0; c < BPR; c++) begin
      send(rb(), 0, s);
      vec++;
      if (s != 0) begin
        errs++; $display("FAIL bp_even_accept stalls %0d required 0", s);
      end
    end
    vec++;
    if (mo0.valid !== 1'b1 || n_out != o) begin
      errs++; $display("FAIL bp_even_hold v%b outputs %0d required v1 outputs %0d", mo0.valid, n_out, o);
    end
    mready = 1'b1;
    for (int c = 0; c < BPR; c++) send(rb(), c == BPR - 1, s);
    drain();
  endtask

  task automatic test_throughput();
    int s, st = 0, o = n_out, l = n_last;
    for (int f = 0; f < 4; f++) begin
      send_frame(4, s);
      st += s;
    end
    drain();
    vec++;
    if (st != 0) begin
      errs++; $display("FAIL tput_stalls got %0d required 0", st);
    end
    vec++;
    if (n_out - o != 16 || n_last - l != 4) begin
      errs++; $display("FAIL tput_counts outputs %0d lasts %0d required 16 4", n_out - o, n_last - l);
    end
  endtask

  task automatic test_early_end();
    int s, o = n_out;
    send(rb(), 0, s);
    send(rb(), 1, s);
    vec++;
    if (err0 !== exp_err || err1 !== exp_err || exp_err !== 1'b1) begin
      errs++; $display("FAIL early_err got %b/%b required %b", err0, err1, exp_err);
    end
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (n_out != o || mo0.valid !== 1'b0) begin
      errs++; $display("FAIL early_no_output outputs %0d v%b required %0d v0", n_out, mo0.valid, o);
    end
    send_frame(2, s);
    drain();
    vec++;
    if (n_out - o != 2 || err0 !== 1'b1 || err1 !== 1'b1) begin
      errs++; $display("FAIL early_recover outputs %0d err %b/%b required 2 1/1", n_out - o, err0, err1);
    end
  endtask

  task automatic test_reset_mid();
    int s, o;
    mready = 1'b0;
    for (int c = 0; c < BPR; c++) send(rb(), 0, s);
    send(rb(), 0, s);
    #2;
    rstn = 1'b0;
    #1;
    vec++;
    if (mo0.valid !== 1'b0 || mo1.valid !== 1'b0 || err0 !== 1'b0) begin
      errs++; $display("FAIL rstmid_drop v%b/%b err %b required 0/0 0", mo0.valid, mo1.valid, err0);
    end
    model_reset();
    @(posedge clk); #1;
    rstn = 1'b1;
    mready = 1'b1;
    o = n_out;
    send_frame(2, s);
    drain();
    vec++;
    if (n_out - o != 2 || err0 !== 1'b0) begin
      errs++; $display("FAIL rstmid_clean outputs %0d err %b required 2 0", n_out - o, err0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_throughput();
    test_early_end();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/maxpool2d_stream.md
Name: maxpool2d_stream

Overview:
Streaming 2x2/stride-2 max-pool stage for the feature-map pipeline. It is the successor to the 1-D pairwise maxpool. Each input beat carries R horizontally adjacent pixels. The block pools pixel pairs horizontally within a beat, then pools vertically across row pairs using a one-row line buffer. It emits one R/2-pixel beat per odd-row input beat, with valid/ready backpressure, frame delimiting and signed/unsigned compare.

Parameters:
R, 4, pixels per input beat; even, >=2
W, 8, bits per pixel
COLS, 16, pixels per image row; COLS % R == 0
SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  block can accept input beat
s_data  in  [R-1:0][W-1:0]  input pixels; element 0 is leftmost
s_last  in  1  last beat of frame
m_valid  out  1  output beat valid
m_ready  in  1  downstream accepts output
m_data  out  [R/2-1:0][W-1:0]  pooled pixels
m_last  out  1  output beat is last of frame
frame_err  out  1  sticky: frame ended off a row-pair boundary

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_data=0, m_last=0, frame_err=0, col=0, row_odd=0. Line buffer contents are not cleared; they are don't-care because each entry is written before it is read.
- Derived constant: BPR = COLS/R beats per row. col counts 0..BPR-1. row_odd is the row-parity flag.
- Accept = s_valid && s_ready.
- s_ready is combinational:
  - row_odd=0: s_ready = 1.
  - row_odd=1: s_ready = !m_valid || m_ready.
- Horizontal max: hmax[j] = max(s_data[2j], s_data[2j+1]), j = 0..R/2-1.
  - Compare is signed iff SIGNED=1.
  - Ties yield the equal value. No width growth.
- Even-row accept: lbuf[col] <= hmax. No output is produced.
- Odd-row accept: m_data[j] <= max(lbuf[col][j], hmax[j]); m_valid <= 1; m_last <= s_last. Latency is 1 cycle from accept to m_valid.
- Output hold: m_valid, m_data and m_last stay stable while m_valid && !m_ready.
- m_valid clears on m_valid && m_ready, unless a new odd-row accept occurs in the same cycle. In that case m_valid stays 1 and new data loads, giving full throughput of 1 beat per cycle.
- Counters on accept:
  - col == BPR-1: col wraps to 0 and row_odd toggles.
  - Otherwise col increments.
- s_last on accept: col and row_odd go to 0 regardless of position.
  - If s_last arrives when not at col==BPR-1 && row_odd==1, frame_err <= 1 (sticky until rstn).
  - The partial even-row data is discarded.
  - An odd-row output already launched is still delivered.
- Reset mid-operation: any pending m_valid beat is dropped. The next accepted beat is treated as row 0, col 0.
- Elaboration-time assertions: R even, R>=2, COLS%R==0, W>=1.

Decomposition:
- Package maxpool_pkg holds:
  - default R/W constants
  - the BPR derivation as a localparam-style function
  - typedef pix_t (logic [W-1:0] at default W), for bench use
- Sub-module maxpool_cmp, parameters W and SIGNED: 2-input combinational max. It is instantiated R/2 times for the horizontal stage and R/2 times for the vertical stage.
- Line buffer is an inferred register array of BPR x (R/2*W) inside the top module.

Test Plan:
- Basic pooling, with R=4, W=8, COLS=8, SIGNED=0, m_ready=1. Stimulus, with s_last on the final beat:
  - row0: [1,2,3,4], [5,6,7,8]
  - row1: [9,0,0,10], [0,0,0,0]
  - Required: two outputs, [9,10] then [6,8] with m_last=1; no outputs during row0.
- Signed mode, SIGNED=1. Stimulus:
  - row0: [8'hFF,8'h01,8'h80,8'h7F]
  - row1: [8'hFE,8'hFD,8'h80,8'h80]
  - Required: SIGNED=1 gives [8'h01,8'h7F]; the same stimulus with SIGNED=0 gives [8'hFF,8'h80].
- Backpressure: hold m_ready=0 for 5 cycles after the first odd-row output.
  - Required: s_ready=0 during odd row; m_data is stable.
  - Required: after m_ready=1, all remaining beats arrive in order with no loss or duplication. Even-row beats are still accepted while m_ready=0.
- Early frame end: s_last on row0 col1.
  - Required: frame_err=1 and stays set; no output.
  - Required: the next full frame pools correctly, starting from an even row.
- Reset mid-odd-row: assert rstn=0 while m_valid=1.
  - Required: m_valid=0 immediately; after release, the first beat is row 0 and the output matches a clean frame.
- Throughput: continuous s_valid, m_ready=1, 4 frames of random data.
  - Required: one output every cycle during odd rows.
  - Required: all outputs match a reference model; m_last count equals 4.
